// File: rtl/io_bridge_fl_if.sv
// io_bridge_fl_if: bundle of every non-clock, non-reset signal of io_bridge_fl.
//
// Integer side (per channel, packed, channel k at [k*NBITS +: NBITS]):
//   in_data / in_valid / in_ready      input channel push handshake
//   out_data / out_valid / out_ready   output channel pop handshake
// Processor side:
//   proc_in / proc_addr_in / proc_req_in        float read of an input FIFO head
//   proc_out / proc_addr_out / proc_out_en      float write into an output FIFO
//   proc_stall                                  hold the processor this cycle
//   stat_stall                                  stall cycle counter (0 when not built)
//
// Modports: slave = the bridge, master = the external side / testbench.
interface io_bridge_fl_if #(
  parameter int unsigned NBITS  = 19,
  parameter int unsigned NBMANT = 19,
  parameter int unsigned NBEXPO = 8,
  parameter int unsigned NUIOIN = 4,
  parameter int unsigned NUIOOU = 4
) ();

  localparam int unsigned FW  = NBMANT + NBEXPO + 1;
  localparam int unsigned AIW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
  localparam int unsigned AOW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

  logic [NUIOIN*NBITS-1:0] in_data;
  logic [NUIOIN-1:0]       in_valid;
  logic [NUIOIN-1:0]       in_ready;

  logic [NUIOOU*NBITS-1:0] out_data;
  logic [NUIOOU-1:0]       out_valid;
  logic [NUIOOU-1:0]       out_ready;

  logic [FW-1:0]           proc_in;
  logic [AIW-1:0]          proc_addr_in;
  logic                    proc_req_in;
  logic [FW-1:0]           proc_out;
  logic [AOW-1:0]          proc_addr_out;
  logic                    proc_out_en;
  logic                    proc_stall;
  logic [15:0]             stat_stall;

  modport slave (
    input  in_data, in_valid, out_ready,
    input  proc_addr_in, proc_req_in, proc_out, proc_addr_out, proc_out_en,
    output in_ready, out_data, out_valid, proc_in, proc_stall, stat_stall
  );

  modport master (
    output in_data, in_valid, out_ready,
    output proc_addr_in, proc_req_in, proc_out, proc_addr_out, proc_out_en,
    input  in_ready, out_data, out_valid, proc_in, proc_stall, stat_stall
  );

endinterface

// File: rtl/io_bridge_fl.sv
// io_bridge_fl: buffered I/O front-end for the floating-point soft processor.
//
// NUIOIN input channels and NUIOOU output channels, each backed by an FDEPTH-entry
// circular FIFO. Input FIFOs hold raw integers; the head of the addressed input FIFO is
// converted to float combinationally for the processor. Processor writes are converted
// float-to-integer before being pushed into the addressed output FIFO. Reads from an
// empty channel or writes to a full channel stall the processor.
//
// Ports:
//   clk   clock
//   rst   asynchronous, active-high reset; discards all FIFO contents
//   bus   io_bridge_fl_if.slave (integer handshakes, processor port, stat_stall)
//
// Float format (FW = NBMANT+NBEXPO+1 bits): {sign, biased exponent, fraction}, bias
// 2^(NBEXPO-1)-1, implied leading one, all-zero word is 0.0. Float-to-integer truncates
// toward zero and saturates to the NBITS two's complement range; exponent 0 reads as 0.
//
// Optional feature: define IO_BRIDGE_STAT_EN to build the saturating stall counter on
// stat_stall; otherwise stat_stall is tied to 0.
module io_bridge_fl #(
  parameter int unsigned NBITS  = 19,
  parameter int unsigned NBMANT = 19,
  parameter int unsigned NBEXPO = 8,
  parameter int unsigned NUIOIN = 4,
  parameter int unsigned NUIOOU = 4,
  parameter int unsigned FDEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  io_bridge_fl_if.slave bus
);

  localparam int unsigned FW   = NBMANT + NBEXPO + 1;
  localparam int unsigned AIW  = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
  localparam int unsigned AOW  = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;
  localparam int unsigned LD   = $clog2(FDEPTH);
  localparam int unsigned PW   = LD + 1;
  localparam int unsigned BIAS = (1 << (NBEXPO - 1)) - 1;
  localparam int unsigned SHW  = NBITS + NBMANT;
  localparam int unsigned SGW  = NBITS + NBMANT + 1;

  // ---------------------------------------------------------------------------------------
  // Conversions
  // ---------------------------------------------------------------------------------------

  function automatic logic [FW-1:0] int2float(input logic [NBITS-1:0] x);
    logic              neg;
    logic [NBITS-1:0]  mag;
    int unsigned       p;
    logic [SHW-1:0]    sh;
    logic [NBMANT-1:0] frac;
    logic [NBEXPO-1:0] expo;
    neg = x[NBITS-1];
    // -2^(NBITS-1) negates to itself, which is the correct unsigned magnitude.
    mag = neg ? (~x + 1'b1) : x;
    p = 0;
    for (int i = 0; i < int'(NBITS); i++) begin
      if (mag[i]) p = i;
    end
    // Park the leading one at the top bit; the NBMANT bits below it are the fraction.
    sh   = SHW'(mag) << (SHW - 1 - p);
    frac = NBMANT'(sh >> (NBITS - 1));
    expo = NBEXPO'(BIAS + p);
    return (mag == '0) ? '0 : {neg, expo, frac};
  endfunction

  function automatic logic [NBITS-1:0] float2int(input logic [FW-1:0] f);
    logic              s;
    logic [NBEXPO-1:0] e;
    logic [NBMANT-1:0] m;
    int                ue;
    logic [SGW-1:0]    sig;
    logic [NBITS-1:0]  mag;
    logic [NBITS-1:0]  res;
    s   = f[FW-1];
    e   = f[FW-2 -: NBEXPO];
    m   = f[NBMANT-1:0];
    ue  = int'(e) - int'(BIAS);
    sig = SGW'({1'b1, m});
    res = '0;
    if (e == '0 || ue < 0) begin
      res = '0;
    end else if (ue >= int'(NBITS) - 1) begin
      res = s ? {1'b1, {(NBITS-1){1'b0}}} : {1'b0, {(NBITS-1){1'b1}}};
    end else begin
      if (ue >= int'(NBMANT)) sig = sig << (ue - int'(NBMANT));
      else                    sig = sig >> (int'(NBMANT) - ue);
      mag = NBITS'(sig);
      res = s ? (~mag + 1'b1) : mag;
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------------------
  // Input channels
  // ---------------------------------------------------------------------------------------

  logic [NBITS-1:0]  in_mem_q [NUIOIN][FDEPTH];
  logic [PW-1:0]     in_wp_q  [NUIOIN];
  logic [PW-1:0]     in_wp_d  [NUIOIN];
  logic [PW-1:0]     in_rp_q  [NUIOIN];
  logic [PW-1:0]     in_rp_d  [NUIOIN];
  logic [NUIOIN-1:0] in_full;
  logic [NUIOIN-1:0] in_empty;
  logic [NUIOIN-1:0] in_ready;
  logic [NUIOIN-1:0] in_push;
  logic [NUIOIN-1:0] in_pop;

  logic              rd_ok;
  logic [AIW-1:0]    rd_sel;
  logic              rd_empty;
  logic [NBITS-1:0]  rd_head;
  logic              rd_stall;

  always_comb begin
    in_full  = '0;
    in_empty = '0;
    for (int k = 0; k < int'(NUIOIN); k++) begin
      in_empty[k] = (in_wp_q[k] == in_rp_q[k]);
      in_full[k]  = (in_wp_q[k][PW-1] != in_rp_q[k][PW-1]) &&
                    (in_wp_q[k][LD-1:0] == in_rp_q[k][LD-1:0]);
    end
  end

  // Ready comes from registered pointers only; a same-cycle pop never frees a full slot.
  assign in_ready     = ~in_full & {NUIOIN{~rst}};
  assign in_push      = bus.in_valid & in_ready;
  assign bus.in_ready = in_ready;

  assign rd_ok    = (32'(bus.proc_addr_in) < NUIOIN);
  assign rd_sel   = rd_ok ? bus.proc_addr_in : '0;
  assign rd_empty = in_empty[rd_sel];
  assign rd_head  = in_mem_q[rd_sel][in_rp_q[rd_sel][LD-1:0]];
  assign rd_stall = bus.proc_req_in & rd_ok & rd_empty & ~rst;

  assign bus.proc_in = (rd_ok && !rd_empty) ? int2float(rd_head) : '0;

  always_comb begin
    in_pop = '0;
    for (int k = 0; k < int'(NUIOIN); k++) begin
      in_pop[k]  = bus.proc_req_in && rd_ok && (rd_sel == AIW'(k)) && !in_empty[k];
      in_wp_d[k] = in_push[k] ? in_wp_q[k] + 1'b1 : in_wp_q[k];
      in_rp_d[k] = in_pop[k]  ? in_rp_q[k] + 1'b1 : in_rp_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(NUIOIN); k++) begin
        in_wp_q[k] <= '0;
        in_rp_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(NUIOIN); k++) begin
        in_wp_q[k] <= in_wp_d[k];
        in_rp_q[k] <= in_rp_d[k];
      end
    end
  end

  // Storage needs no reset: the pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(NUIOIN); k++) begin
      if (in_push[k]) in_mem_q[k][in_wp_q[k][LD-1:0]] <= bus.in_data[k*NBITS +: NBITS];
    end
  end

  // ---------------------------------------------------------------------------------------
  // Output channels
  // ---------------------------------------------------------------------------------------

  logic [NBITS-1:0]        out_mem_q [NUIOOU][FDEPTH];
  logic [PW-1:0]           out_wp_q  [NUIOOU];
  logic [PW-1:0]           out_wp_d  [NUIOOU];
  logic [PW-1:0]           out_rp_q  [NUIOOU];
  logic [PW-1:0]           out_rp_d  [NUIOOU];
  logic [NUIOOU-1:0]       out_full;
  logic [NUIOOU-1:0]       out_empty;
  logic [NUIOOU-1:0]       out_push;
  logic [NUIOOU-1:0]       out_pop;
  logic [NUIOOU*NBITS-1:0] out_data;

  logic                    wr_ok;
  logic [AOW-1:0]          wr_sel;
  logic                    wr_full;
  logic [NBITS-1:0]        wr_word;
  logic                    wr_stall;

  always_comb begin
    out_full  = '0;
    out_empty = '0;
    for (int j = 0; j < int'(NUIOOU); j++) begin
      out_empty[j] = (out_wp_q[j] == out_rp_q[j]);
      out_full[j]  = (out_wp_q[j][PW-1] != out_rp_q[j][PW-1]) &&
                     (out_wp_q[j][LD-1:0] == out_rp_q[j][LD-1:0]);
    end
  end

  assign wr_ok    = (32'(bus.proc_addr_out) < NUIOOU);
  assign wr_sel   = wr_ok ? bus.proc_addr_out : '0;
  assign wr_full  = out_full[wr_sel];
  assign wr_word  = float2int(bus.proc_out);
  assign wr_stall = bus.proc_out_en & wr_ok & wr_full & ~rst;

  assign out_pop       = ~out_empty & bus.out_ready;
  assign bus.out_valid = ~out_empty;

  always_comb begin
    out_push = '0;
    out_data = '0;
    for (int j = 0; j < int'(NUIOOU); j++) begin
      out_push[j] = bus.proc_out_en && wr_ok && (wr_sel == AOW'(j)) && !out_full[j];
      out_wp_d[j] = out_push[j] ? out_wp_q[j] + 1'b1 : out_wp_q[j];
      out_rp_d[j] = out_pop[j]  ? out_rp_q[j] + 1'b1 : out_rp_q[j];
      // Mask the stale head so an empty channel presents 0.
      if (!out_empty[j]) out_data[j*NBITS +: NBITS] = out_mem_q[j][out_rp_q[j][LD-1:0]];
    end
  end

  assign bus.out_data = out_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < int'(NUIOOU); j++) begin
        out_wp_q[j] <= '0;
        out_rp_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < int'(NUIOOU); j++) begin
        out_wp_q[j] <= out_wp_d[j];
        out_rp_q[j] <= out_rp_d[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < int'(NUIOOU); j++) begin
      if (out_push[j]) out_mem_q[j][out_wp_q[j][LD-1:0]] <= wr_word;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Stall and statistics
  // ---------------------------------------------------------------------------------------

  assign bus.proc_stall = rd_stall | wr_stall;

`ifdef IO_BRIDGE_STAT_EN
  logic [15:0] stat_q;
  logic [15:0] stat_d;

  always_comb begin
    stat_d = stat_q;
    if (bus.proc_stall && (stat_q != 16'hFFFF)) stat_d = stat_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stat_q <= '0;
    else     stat_q <= stat_d;
  end

  assign bus.stat_stall = stat_q;
`else
  assign bus.stat_stall = '0;
`endif

endmodule

// File: tb/tb_io_bridge_fl.sv
// Directed bench for io_bridge_fl with hand-computed float/integer vectors.
module tb_io_bridge_fl;

  localparam int unsigned NBITS  = 19;
  localparam int unsigned NBMANT = 19;
  localparam int unsigned NBEXPO = 8;
  localparam int unsigned NUIOIN = 4;
  localparam int unsigned NUIOOU = 4;
  localparam int unsigned FDEPTH = 4;

`ifdef IO_BRIDGE_STAT_EN
  localparam bit STAT_ON = 1'b1;
`else
  localparam bit STAT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  io_bridge_fl_if #(
    .NBITS (NBITS),
    .NBMANT(NBMANT),
    .NBEXPO(NBEXPO),
    .NUIOIN(NUIOIN),
    .NUIOOU(NUIOOU)
  ) bus ();

  io_bridge_fl #(
    .NBITS (NBITS),
    .NBMANT(NBMANT),
    .NBEXPO(NBEXPO),
    .NUIOIN(NUIOIN),
    .NUIOOU(NUIOOU),
    .FDEPTH(FDEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // int2float(1), (2), (3), (4)
  logic [27:0] exp_rd [4] = '{28'h3F80000, 28'h4000000, 28'h4040000, 28'h4080000};
  // floats 5.0, -3.75, 2^30, -1.0
  logic [27:0] wr_f   [4] = '{28'h40A0000, 28'hC070000, 28'h4E80000, 28'hBF80000};
  // their integers (truncate, saturate), then the late write of 3.0
  logic [18:0] exp_out [4] = '{19'h7FFFD, 19'h3FFFF, 19'h7FFFF, 19'h00003};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_in(input int k, input logic [18:0] v);
    bus.in_data[k*NBITS +: NBITS] = v;
  endtask

  function automatic logic [18:0] out_slice(input int j);
    return bus.out_data[j*NBITS +: NBITS];
  endfunction

  initial begin
    bus.in_data       = '0;
    bus.in_valid      = '0;
    bus.out_ready     = '0;
    bus.proc_addr_in  = '0;
    bus.proc_req_in   = 1'b0;
    bus.proc_out      = '0;
    bus.proc_addr_out = '0;
    bus.proc_out_en   = 1'b0;

    // Reset state
    step();
    step();
    check("rst_in_ready", bus.in_ready, 4'h0);
    check("rst_out_valid", bus.out_valid, 4'h0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_proc_in", bus.proc_in, '0);
    check("rst_stall", bus.proc_stall, 1'b0);
    check("rst_stat", bus.stat_stall, 16'h0);
    rst = 1'b0;
    settle();
    check("post_rst_in_ready", bus.in_ready, 4'hF);

    // Single word 5 on ch0, then -1 on ch1
    set_in(0, 19'd5);
    bus.in_valid = 4'b0001;
    step();
    bus.in_valid = 4'b0000;
    bus.proc_addr_in = 2'd0;
    settle();
    check("t1_proc_in_5", bus.proc_in, 28'h40A0000);
    bus.proc_req_in = 1'b1;
    settle();
    check("t1_no_stall", bus.proc_stall, 1'b0);
    step();
    bus.proc_req_in = 1'b0;
    settle();
    check("t1_empty_proc_in", bus.proc_in, '0);
    check("t1_in_ready0", bus.in_ready[0], 1'b1);
    set_in(1, 19'h7FFFF);
    bus.in_valid = 4'b0010;
    step();
    bus.in_valid = 4'b0000;
    bus.proc_addr_in = 2'd1;
    settle();
    check("t1_proc_in_m1", bus.proc_in, 28'hBF80000);
    bus.proc_req_in = 1'b1;
    step();
    bus.proc_req_in = 1'b0;

    // Fill ch2, fifth word refused, ordered read-back
    bus.in_valid = 4'b0100;
    for (int i = 1; i <= 4; i++) begin
      set_in(2, 19'(i));
      step();
    end
    check("t2_full_ready", bus.in_ready[2], 1'b0);
    set_in(2, 19'd5);
    step();
    bus.in_valid = 4'b0000;
    check("t2_still_full", bus.in_ready[2], 1'b0);
    bus.proc_addr_in = 2'd2;
    bus.proc_req_in  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("t2_read%0d", i), bus.proc_in, exp_rd[i]);
      step();
    end
    bus.proc_req_in = 1'b0;
    settle();
    check("t2_drained_proc_in", bus.proc_in, '0);
    check("t2_drained_ready", bus.in_ready[2], 1'b1);

    // Read stall on empty ch1 for three cycles, push lands on the third
    bus.proc_addr_in = 2'd1;
    bus.proc_req_in  = 1'b1;
    settle();
    check("t3_stall_c1", bus.proc_stall, 1'b1);
    step();
    settle();
    check("t3_stall_c2", bus.proc_stall, 1'b1);
    step();
    set_in(1, 19'd7);
    bus.in_valid = 4'b0010;
    settle();
    check("t3_stall_c3", bus.proc_stall, 1'b1);
    step();
    bus.in_valid = 4'b0000;
    settle();
    check("t3_stall_drop", bus.proc_stall, 1'b0);
    check("t3_proc_in_7", bus.proc_in, 28'h40E0000);
    step();
    bus.proc_req_in = 1'b0;
    settle();
    check("t3_stat", bus.stat_stall, STAT_ON ? 16'd3 : 16'd0);

    // Fill output ch3 with the sink held off, fifth write stalls
    bus.out_ready     = 4'b0000;
    bus.proc_addr_out = 2'd3;
    bus.proc_out_en   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.proc_out = wr_f[i];
      step();
    end
    bus.proc_out = 28'h4040000;
    settle();
    check("t4_out_valid", bus.out_valid, 4'b1000);
    check("t4_head_5", out_slice(3), 19'd5);
    check("t4_stall_full", bus.proc_stall, 1'b1);
    step();
    check("t4_stall_held", bus.proc_stall, 1'b1);
    bus.out_ready = 4'b1000;
    settle();
    check("t4_stall_pop_pending", bus.proc_stall, 1'b1);
    step();
    bus.out_ready = 4'b0000;
    settle();
    check("t4_stall_released", bus.proc_stall, 1'b0);
    check("t4_head_after_pop", out_slice(3), exp_out[0]);
    step();
    bus.proc_out_en = 1'b0;
    bus.out_ready   = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("t4_drain%0d", i), out_slice(3), exp_out[i]);
      step();
    end
    bus.out_ready = 4'b0000;
    settle();
    check("t4_out_empty", bus.out_valid, 4'b0000);
    check("t4_stat", bus.stat_stall, STAT_ON ? 16'd5 : 16'd0);

    // Half-full ch0: push and pop every cycle across the pointer wrap
    bus.proc_addr_in = 2'd0;
    bus.in_valid     = 4'b0001;
    set_in(0, 19'd1);
    step();
    set_in(0, 19'd2);
    step();
    bus.proc_req_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(0, 19'(1 << (i + 2)));
      settle();
      check($sformatf("t5_pop%0d", i), bus.proc_in, 28'(127 + i) << 19);
      check($sformatf("t5_ready%0d", i), bus.in_ready[0], 1'b1);
      step();
    end
    bus.in_valid = 4'b0000;
    for (int i = 10; i < 12; i++) begin
      settle();
      check($sformatf("t5_tail%0d", i), bus.proc_in, 28'(127 + i) << 19);
      step();
    end
    bus.proc_req_in = 1'b0;
    settle();
    check("t5_empty", bus.proc_in, '0);

    // Reset with input and output FIFOs partly full
    set_in(0, 19'd9);
    set_in(1, 19'd9);
    bus.in_valid      = 4'b0011;
    bus.proc_out      = 28'h40A0000;
    bus.proc_addr_out = 2'd0;
    bus.proc_out_en   = 1'b1;
    step();
    bus.in_valid      = 4'b0000;
    bus.proc_addr_out = 2'd2;
    step();
    bus.proc_out_en = 1'b0;
    settle();
    check("t6_pre_out_valid", bus.out_valid, 4'b0101);
    rst = 1'b1;
    settle();
    check("t6_rst_in_ready", bus.in_ready, 4'h0);
    check("t6_rst_out_valid", bus.out_valid, 4'h0);
    check("t6_rst_out_data", bus.out_data, '0);
    check("t6_rst_proc_in", bus.proc_in, '0);
    step();
    rst = 1'b0;
    settle();
    check("t6_post_in_ready", bus.in_ready, 4'hF);
    check("t6_post_out_valid", bus.out_valid, 4'h0);
    check("t6_post_proc_in0", bus.proc_in, '0);
    bus.proc_addr_in = 2'd1;
    settle();
    check("t6_post_proc_in1", bus.proc_in, '0);
    check("t6_post_stat", bus.stat_stall, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_bridge_fl.md
# io_bridge_fl

Parametrised I/O front-end for the floating-point soft processor. Replaces the fixed int2float/float2int plus address-decoder wrapping with NUIOIN buffered input channels and NUIOOU buffered output channels, each with a per-channel FIFO and valid/ready handshake on the integer side. Integer-to-float and float-to-integer conversion uses the codebase `int2float`/`float2int` modules. The block sits between external integer sources/sinks and the `proc_fl` I/O ports, and stalls the processor on empty/full channels.

## Interface
- NBITS, 19: external integer width, two's complement
- NBMANT, 19: processor mantissa width
- NBEXPO, 8: processor exponent width; float word FW = NBMANT+NBEXPO+1
- NUIOIN, 4: input channel count, ≥1
- NUIOOU, 4: output channel count, ≥1
- FDEPTH, 4: entries per channel FIFO, power of 2, ≥2
- AIW/AOW (derived): max(1, clog2(NUIOIN)) and max(1, clog2(NUIOOU))

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_data  in  NUIOIN*NBITS  packed input words, channel k at [k*NBITS +: NBITS]
- in_valid  in  NUIOIN  per-channel source valid
- in_ready  out  NUIOIN  per-channel FIFO not full
- out_data  out  NUIOOU*NBITS  packed output words, FIFO heads
- out_valid  out  NUIOOU  per-channel FIFO not empty
- out_ready  in  NUIOOU  per-channel sink ready
- proc_in  out  FW  float of addressed input FIFO head
- proc_addr_in  in  AIW  input channel select
- proc_req_in  in  1  processor read strobe
- proc_out  in  FW  float result from processor
- proc_addr_out  in  AOW  output channel select
- proc_out_en  in  1  processor write strobe
- proc_stall  out  1  hold processor this cycle
- stat_stall  out  16  stall cycle count (see Configuration)

## Operation
- Each channel: circular FIFO, read/write pointers log2(FDEPTH)+1 bits, full when MSBs differ and rest equal, empty when equal.
- Input push: in_valid[k] & in_ready[k]; stores raw integer. in_ready[k] = !full[k]; forced 0 while rst high.
- proc_in = int2float(head of channel proc_addr_in), combinational; 0 if that FIFO empty or address ≥ NUIOIN.
- Read: proc_req_in & !empty[addr] pops the head. proc_req_in & empty[addr] (addr valid) → proc_stall=1, no pop.
- Write: proc_out_en & !full[addr] pushes float2int(proc_out) (codebase saturation/rounding) into output FIFO addr. proc_out_en & full[addr] → proc_stall=1, no push.
- proc_stall = read-stall OR write-stall, combinational; processor repeats the request while held.
- Output pop: out_valid[j] & out_ready[j]. out_valid[j] = !empty[j]; out_data slice = head.
- Out-of-range address: request ignored, no stall, no pointer change.
- Simultaneous push and pop on one FIFO: both occur, occupancy unchanged. Full FIFO with pop pending: push still refused (in_ready/full registered state only).

## Timing
- Reset: all pointers 0, in_ready=0 during rst then all 1, out_valid=0, out_data=0, proc_in=0, proc_stall=0, stat_stall=0.
- Reset mid-operation: all FIFO contents discarded immediately; no partial pushes or pops survive.
- Input latency: word pushed at edge n visible on proc_in (if addressed) after edge n, usable in cycle n+1.
- Processor write at edge n → out_valid high cycle n+1.
- Full-throughput: one push and one pop per channel per cycle, all channels independent.
- Pointer wrap-around at FDEPTH transparent; ordering strictly FIFO per channel.

## Configuration
- IO_BRIDGE_STAT_EN defined: stat_stall counts cycles with proc_stall=1, saturates at 16'hFFFF, cleared only by rst.
- Undefined: counter not built, stat_stall tied to 0.

## Test plan
- Reset then push 5 to ch0, read ch0 next cycle → proc_in = int2float(5), pop; ch0 empty, in_ready[0]=1.
- Push FDEPTH words 1..4 to ch2 with no reads → in_ready[2]=0 after 4th; 5th in_valid ignored; reads return 1,2,3,4 in order.
- proc_req_in on empty ch1 for 3 cycles, then push 7 → proc_stall high 3 cycles, drops next cycle after push is visible; stat_stall=3 (macro on), 0 (off).
- Fill out ch3 with out_ready=0, 5th proc_out_en to ch3 → proc_stall=1; raise out_ready → one pop, write accepted next cycle.
- Simultaneous push and pop on half-full ch0 for 10 cycles → occupancy constant, data order preserved across pointer wrap.
- Assert rst with all FIFOs partly full → out_valid=0, in_ready=0 during reset, all empty after release.
